// File: rtl/fetch_exec_unit_pkg.sv
// simple_cpu_pkg: shared opcodes, FSM states and widths for fetch_exec_unit and alu4
package simple_cpu_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;
  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT, ST_PAUSE} state_t;
endpackage

// File: rtl/fetch_exec_unit_if.sv
// fetch_exec_unit_if: program-memory bus (addr out of the unit, opcode/data back one clock later)
interface fetch_exec_unit_if;
  import simple_cpu_pkg::*;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] opcode;
  logic [DATA_W-1:0] data;
  modport master (output addr, input opcode, input data);
  modport slave (input addr, output opcode, output data);
endinterface

// File: rtl/fetch_exec_unit_alu4.sv
// alu4: combinational ALU; opcode/acc/data/c_in in, result/carry_out/zero_out/write_acc out
module alu4
  import simple_cpu_pkg::*;
(
  input  logic [DATA_W-1:0] opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] data,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              zero_out,
  output logic              write_acc
);
  logic [DATA_W:0] w_sum;
  assign w_sum = {1'b0, acc} + {1'b0, data};
  always_comb begin
    result = acc;
    carry_out = c_in;
    write_acc = 1'b1;
    case (opcode)
      OP_LDI: result = data;
      OP_ADD: {carry_out, result} = w_sum;
      OP_SUB: begin result = acc - data; carry_out = acc < data; end
      OP_AND: begin result = acc & data; carry_out = 1'b0; end
      OP_OR:  begin result = acc | data; carry_out = 1'b0; end
      OP_XOR: begin result = acc ^ data; carry_out = 1'b0; end
      default: write_acc = 1'b0;
    endcase
  end
  assign zero_out = result == '0;
endmodule

// File: rtl/fetch_exec_unit.sv
// fetch_exec_unit: 2-clock fetch/exec CPU stage (clk, reset, mem bus, acc/out_port/out_valid/zero/carry/halted; SINGLE_STEP_EN adds step/paused)
module fetch_exec_unit
  import simple_cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 4'h0,
  parameter int                PC_STEP  = 2
) (
  input  logic               clk,
  input  logic               reset,
`ifdef SINGLE_STEP_EN
  input  logic               step,
  output logic               paused,
`endif
  fetch_exec_unit_if.master  mem,
  output logic [DATA_W-1:0]  acc,
  output logic [DATA_W-1:0]  out_port,
  output logic               out_valid,
  output logic               zero,
  output logic               carry,
  output logic               halted
);
  state_t r_state, w_next, w_after, w_resume;
  logic [ADDR_W-1:0] r_pc, w_pc_seq, w_pc_next;
  logic [DATA_W-1:0] r_acc, r_out_port, w_result;
  logic r_out_valid, r_zero, r_carry, w_c, w_z, w_wr;
  alu4 u_alu (
    .opcode(mem.opcode), .acc(r_acc), .data(mem.data), .c_in(r_carry),
    .result(w_result), .carry_out(w_c), .zero_out(w_z), .write_acc(w_wr)
  );
`ifdef SINGLE_STEP_EN
  assign w_after = ST_PAUSE;
  assign w_resume = step ? ST_FETCH : ST_PAUSE;
  assign paused = r_state == ST_PAUSE;
`else
  assign w_after = ST_FETCH;
  assign w_resume = ST_FETCH;
`endif
  assign w_pc_seq = r_pc + ADDR_W'(PC_STEP);
  assign w_pc_next = mem.opcode == OP_JMP ? mem.data :
                     (mem.opcode == OP_JZ && r_zero) ? mem.data :
                     mem.opcode == OP_HLT ? r_pc : w_pc_seq;
  always_comb begin
    w_next = r_state == ST_FETCH ? ST_EXEC :
             r_state == ST_EXEC ? (mem.opcode == OP_HLT ? ST_HALT : w_after) :
             r_state == ST_PAUSE ? w_resume : ST_HALT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc <= RESET_PC;
      r_acc <= '0;
      r_out_port <= '0;
      r_out_valid <= 1'b0;
      r_zero <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out_valid <= 1'b0;
      if (r_state == ST_EXEC) begin
        r_pc <= w_pc_next;
        if (w_wr) begin
          r_acc <= w_result;
          r_zero <= w_z;
          r_carry <= w_c;
        end
        if (mem.opcode == OP_OUT) begin
          r_out_port <= r_acc;
          r_out_valid <= 1'b1;
        end
      end
    end
  end
  assign mem.addr = r_pc;
  assign acc = r_acc;
  assign out_port = r_out_port;
  assign out_valid = r_out_valid;
  assign zero = r_zero;
  assign carry = r_carry;
  assign halted = r_state == ST_HALT;
endmodule

// File: tb/tb_fetch_exec_unit.sv
// tb_fetch_exec_unit: table, hand-sequence and random-program checks of fetch_exec_unit against an ISA model
module tb_fetch_exec_unit;
  import simple_cpu_pkg::*;
  typedef struct {
    logic [3:0] op, d, e_addr, e_acc, e_out;
    bit e_z, e_c, e_ov, e_halt;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] acc, out_port;
  logic out_valid, zero, carry, halted;
  logic [3:0] mem [16];
  int vectors = 0;
  int miscompares = 0;
  vec_t tbl [17];
  logic [3:0] ea [8];
  bit eo [8], eh [8];
  logic [3:0] m_pc, m_acc, m_out;
  bit m_z, m_c, m_ov, m_halt;
`ifdef SINGLE_STEP_EN
  logic step = 1'b1;
  logic paused;
  bit pend = 1'b0;
`endif
  fetch_exec_unit_if mif ();
  fetch_exec_unit dut (
    .clk(clk), .reset(reset),
`ifdef SINGLE_STEP_EN
    .step(step), .paused(paused),
`endif
    .mem(mif), .acc(acc), .out_port(out_port), .out_valid(out_valid),
    .zero(zero), .carry(carry), .halted(halted)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    mif.opcode <= mem[mif.addr];
    mif.data <= mem[mif.addr + 4'd1];
  end
  task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_addr", mif.addr, 4'h0);
    chk("rst_acc", acc, 4'h0);
    chk("rst_out_port", out_port, 4'h0);
    chk("rst_out_valid", {3'b0, out_valid}, 4'h0);
    chk("rst_zero", {3'b0, zero}, 4'h0);
    chk("rst_carry", {3'b0, carry}, 4'h0);
    chk("rst_halted", {3'b0, halted}, 4'h0);
`ifdef SINGLE_STEP_EN
    chk("rst_paused", {3'b0, paused}, 4'h0);
    pend = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic wr(input logic [3:0] pc, input logic [3:0] op, input logic [3:0] d);
    mem[pc] = op;
    mem[pc + 4'd1] = d;
  endtask
  task automatic step_instr(input logic [3:0] op);
`ifdef SINGLE_STEP_EN
    if (pend) @(posedge clk);
    pend = op != OP_HLT;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic iss(input logic [3:0] op, input logic [3:0] d);
    int s;
    m_ov = 1'b0;
    s = 0;
    if (m_halt) return;
    case (op)
      OP_LDI: m_acc = d;
      OP_ADD: begin s = int'(m_acc) + int'(d); m_acc = 4'(s); m_c = s > 15; end
      OP_SUB: begin m_c = m_acc < d; m_acc = 4'((int'(m_acc) - int'(d) + 16) % 16); end
      OP_AND: begin m_acc = m_acc & d; m_c = 1'b0; end
      OP_OR:  begin m_acc = m_acc | d; m_c = 1'b0; end
      OP_XOR: begin m_acc = m_acc ^ d; m_c = 1'b0; end
      OP_OUT: begin m_out = m_acc; m_ov = 1'b1; end
      OP_HLT: m_halt = 1'b1;
      default: ;
    endcase
    if (op <= OP_XOR) m_z = m_acc == 4'd0;
    m_pc = op == OP_JMP ? d : (op == OP_JZ && m_z) ? d : m_halt ? m_pc : 4'((int'(m_pc) + 2) % 16);
  endtask
  initial begin
    logic [3:0] cur;
    logic [3:0] op, d;
    for (int i = 0; i < 16; i++) mem[i] = 4'h9;
    tbl[0]  = '{OP_LDI, 4'd15, 4'd2,  4'd15, 4'd0,  0, 0, 0, 0};
    tbl[1]  = '{OP_ADD, 4'd1,  4'd4,  4'd0,  4'd0,  1, 1, 0, 0};
    tbl[2]  = '{OP_SUB, 4'd1,  4'd6,  4'd15, 4'd0,  0, 1, 0, 0};
    tbl[3]  = '{OP_LDI, 4'd0,  4'd8,  4'd0,  4'd0,  1, 1, 0, 0};
    tbl[4]  = '{OP_JZ,  4'd10, 4'd10, 4'd0,  4'd0,  1, 1, 0, 0};
    tbl[5]  = '{OP_LDI, 4'd3,  4'd12, 4'd3,  4'd0,  0, 1, 0, 0};
    tbl[6]  = '{OP_JZ,  4'd10, 4'd14, 4'd3,  4'd0,  0, 1, 0, 0};
    tbl[7]  = '{4'h9,   4'd0,  4'd0,  4'd3,  4'd0,  0, 1, 0, 0};
    tbl[8]  = '{OP_AND, 4'd5,  4'd2,  4'd1,  4'd0,  0, 0, 0, 0};
    tbl[9]  = '{OP_OR,  4'd6,  4'd4,  4'd7,  4'd0,  0, 0, 0, 0};
    tbl[10] = '{OP_XOR, 4'd7,  4'd6,  4'd0,  4'd0,  1, 0, 0, 0};
    tbl[11] = '{OP_JMP, 4'd15, 4'd15, 4'd0,  4'd0,  1, 0, 0, 0};
    tbl[12] = '{OP_LDI, 4'd12, 4'd1,  4'd12, 4'd0,  0, 0, 0, 0};
    tbl[13] = '{OP_OUT, 4'd0,  4'd3,  4'd12, 4'd12, 0, 0, 1, 0};
    tbl[14] = '{OP_ADD, 4'd5,  4'd5,  4'd1,  4'd12, 0, 1, 0, 0};
    tbl[15] = '{OP_JZ,  4'd9,  4'd7,  4'd1,  4'd12, 0, 1, 0, 0};
    tbl[16] = '{OP_HLT, 4'd0,  4'd7,  4'd1,  4'd12, 0, 1, 0, 1};
    do_reset();
    cur = 4'h0;
    for (int i = 0; i < 17; i++) begin
      wr(cur, tbl[i].op, tbl[i].d);
      step_instr(tbl[i].op);
      chk($sformatf("tbl%0d_addr", i), mif.addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_acc", i), acc, tbl[i].e_acc);
      chk($sformatf("tbl%0d_zero", i), {3'b0, zero}, {3'b0, tbl[i].e_z});
      chk($sformatf("tbl%0d_carry", i), {3'b0, carry}, {3'b0, tbl[i].e_c});
      chk($sformatf("tbl%0d_out_valid", i), {3'b0, out_valid}, {3'b0, tbl[i].e_ov});
      chk($sformatf("tbl%0d_out_port", i), out_port, tbl[i].e_out);
      chk($sformatf("tbl%0d_halted", i), {3'b0, halted}, {3'b0, tbl[i].e_halt});
      cur = tbl[i].e_addr;
    end
`ifndef SINGLE_STEP_EN
    ea = '{4'd0, 4'd2, 4'd2, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
    eo = '{0, 0, 0, 1, 0, 0, 0, 0};
    eh = '{0, 0, 0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 16; i++) mem[i] = 4'h9;
    wr(4'd0, OP_LDI, 4'hC);
    wr(4'd2, OP_OUT, 4'h0);
    wr(4'd4, OP_HLT, 4'h0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("seq_addr%0d", i), mif.addr, ea[i]);
      chk($sformatf("seq_out_valid%0d", i), {3'b0, out_valid}, {3'b0, eo[i]});
      chk($sformatf("seq_halted%0d", i), {3'b0, halted}, {3'b0, eh[i]});
    end
    chk("seq_out_port", out_port, 4'hC);
`endif
    for (int i = 0; i < 16; i++) mem[i] = 4'h9;
    wr(4'd0, OP_LDI, 4'd13);
    wr(4'd2, OP_ADD, 4'd3);
    do_reset();
    step_instr(OP_LDI);
    chk("ar_pre_acc", acc, 4'd13);
`ifdef SINGLE_STEP_EN
    @(posedge clk);
`endif
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_acc", acc, 4'd0);
    chk("ar_addr", mif.addr, 4'd0);
    chk("ar_zero", {3'b0, zero}, 4'd0);
    chk("ar_carry", {3'b0, carry}, 4'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
`ifdef SINGLE_STEP_EN
    pend = 1'b0;
`endif
    step_instr(OP_LDI);
    chk("ar_re_acc1", acc, 4'd13);
    step_instr(OP_ADD);
    chk("ar_re_acc2", acc, 4'd0);
    chk("ar_re_carry", {3'b0, carry}, 4'd1);
    chk("ar_re_zero", {3'b0, zero}, 4'd1);
    chk("ar_re_addr", mif.addr, 4'd4);
`ifdef SINGLE_STEP_EN
    wr(4'd0, OP_LDI, 4'd1);
    wr(4'd2, OP_LDI, 4'd2);
    do_reset();
    step = 1'b0;
    step_instr(OP_LDI);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("ss_paused%0d", i), {3'b0, paused}, 4'd1);
      chk($sformatf("ss_addr%0d", i), mif.addr, 4'd2);
      @(negedge clk);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    chk("ss_acc", acc, 4'd2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("ss2_paused%0d", i), {3'b0, paused}, 4'd1);
      chk($sformatf("ss2_addr%0d", i), mif.addr, 4'd4);
      @(negedge clk);
    end
    step = 1'b1;
`endif
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
      do_reset();
      m_pc = 4'd0; m_acc = 4'd0; m_out = 4'd0;
      m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0; m_ov = 1'b0;
      for (int k = 0; k < 30 && !m_halt; k++) begin
        op = mem[m_pc];
        d = mem[m_pc + 4'd1];
        iss(op, d);
        step_instr(op);
        chk($sformatf("rnd%0d_%0d_addr", p, k), mif.addr, m_pc);
        chk($sformatf("rnd%0d_%0d_acc", p, k), acc, m_acc);
        chk($sformatf("rnd%0d_%0d_zero", p, k), {3'b0, zero}, {3'b0, m_z});
        chk($sformatf("rnd%0d_%0d_carry", p, k), {3'b0, carry}, {3'b0, m_c});
        chk($sformatf("rnd%0d_%0d_ov", p, k), {3'b0, out_valid}, {3'b0, m_ov});
        chk($sformatf("rnd%0d_%0d_out", p, k), out_port, m_out);
        chk($sformatf("rnd%0d_%0d_halted", p, k), {3'b0, halted}, {3'b0, m_halt});
      end
      if (m_halt) begin
        repeat (3) @(negedge clk);
        chk($sformatf("rnd%0d_hold_addr", p), mif.addr, m_pc);
        chk($sformatf("rnd%0d_hold_acc", p), acc, m_acc);
        chk($sformatf("rnd%0d_hold_halted", p), {3'b0, halted}, 4'd1);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
